// File: rtl/wb_result_packer.sv
// wb_result_packer: packs sign-extended two-lane writeback results into 64-bit words
// and streams them through a FIFO to a ready/valid port with a per-operation last flag.
module wb_result_packer #(
    parameter int data_width = 25,
    parameter int fifo_depth = 64,
    parameter int cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [data_width-1:0] out_port0,
    input  logic [data_width-1:0] out_port1,
    input  logic                  port0_valid,
    input  logic                  port1_valid,
    input  logic                  end_op,
    output logic [63:0]           m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  overflow,
    output logic [cnt_width-1:0]  word_cnt,
    output logic                  done
);
    localparam int AW = $clog2(fifo_depth);
    typedef enum logic [2:0] {IDLE, RUN, FLUSH_STAGE, FLUSH_HOLD, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic ingress, flush_s, flush_h;
    logic hv, sv, accept, two, form, lost, push, pop, full, empty, wr, drop;
    logic [31:0] r0, r1, hold;
    logic [63:0] word, stage;
    logic [64:0] push_d;
    logic [64:0] mem [fifo_depth];
    logic [AW:0] wp, rp;
    assign r0 = 32'($signed(out_port0));
    assign r1 = 32'($signed(out_port1));
    assign accept = ingress && port0_valid;
    assign lost = !ingress && (port0_valid || port1_valid);
    assign two = port0_valid && port1_valid;
    assign form = accept && (two || hv);
    assign word = (two && !hv) ? {r1, r0} : {r0, hold};
    assign push = (form && sv) || flush_s || flush_h;
    assign push_d = flush_h ? {1'b1, 32'b0, hold} : {flush_s && !hv, stage};
    assign empty = wp == rp;
    assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign pop = !empty && (!m_valid || m_ready);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr = push && (!full || pop);
    assign drop = push && !wr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:        state_n = port0_valid ? (end_op ? FLUSH_STAGE : RUN) : (end_op ? DONE : IDLE);
            RUN:         state_n = end_op ? FLUSH_STAGE : RUN;
            FLUSH_STAGE: state_n = (sv || hv) ? FLUSH_HOLD : DRAIN;
            FLUSH_HOLD:  state_n = DRAIN;
            DRAIN:       state_n = (empty && !m_valid) ? DONE : DRAIN;
            DONE:        state_n = IDLE;
            default:     state_n = IDLE;
        endcase
    end
    always_comb begin
        ingress = state == IDLE || state == RUN;
        flush_s = state == FLUSH_STAGE && sv;
        flush_h = state == FLUSH_HOLD && hv;
        done = state == DONE;
    end
    always_ff @(posedge clk)
        if (wr) mem[wp[AW-1:0]] <= push_d;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hv <= 1'b0;
            hold <= '0;
            sv <= 1'b0;
            stage <= '0;
            wp <= '0;
            rp <= '0;
            m_valid <= 1'b0;
            m_data <= '0;
            m_last <= 1'b0;
            overflow <= 1'b0;
            word_cnt <= '0;
        end else begin
            hv <= accept ? (two ? hv : !hv) : hv && !flush_h;
            if (accept && two == hv) hold <= two ? r1 : r0;
            sv <= form ? 1'b1 : sv && !flush_s;
            if (form) stage <= word;
            if (wr) wp <= wp + 1'b1;
            if (pop) begin
                rp <= rp + 1'b1;
                {m_last, m_data} <= mem[rp[AW-1:0]];
                m_valid <= 1'b1;
            end else if (m_ready) m_valid <= 1'b0;
            if (state == IDLE && port0_valid) begin
                overflow <= 1'b0;
                word_cnt <= '0;
            end else begin
                if (drop || lost) overflow <= 1'b1;
                if (m_valid && m_ready && !(&word_cnt)) word_cnt <= word_cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_wb_result_packer.sv
// tb_wb_result_packer: directed stimulus; expected words come from packing the
// driven result list in order, checked on every downstream handshake.
module tb_wb_result_packer;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    logic [24:0] out_port0 = 0, out_port1 = 0;
    logic port0_valid = 0, port1_valid = 0, end_op = 0, m_ready = 1;
    logic [63:0] m_data;
    logic m_valid, m_last, overflow, done;
    logic [15:0] word_cnt;
    int checks = 0, errors = 0, delivered = 0;
    int v[$];
    logic [64:0] exp_q[$];
    logic [64:0] w;
    logic [63:0] held, first_word, last_word;
    logic stalled = 0, last_flag;

    wb_result_packer dut (
        .clk(clk), .rst_n(rst_n), .out_port0(out_port0), .out_port1(out_port1),
        .port0_valid(port0_valid), .port1_valid(port1_valid), .end_op(end_op),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .overflow(overflow), .word_cnt(word_cnt), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic add(input int x);
        v.push_back(x);
    endtask

    // Results pair up in arrival order; an odd tail is zero-filled; words drop_lo..drop_hi are lost.
    task automatic build(input int drop_lo, input int drop_hi);
        logic [64:0] q[$];
        for (int k = 0; k < v.size(); k += 2)
            q.push_back({1'b0, (k + 1 < v.size()) ? 32'(v[k+1]) : 32'd0, 32'(v[k])});
        for (int k = drop_hi; k >= drop_lo; k--) q.delete(k);
        if (q.size() > 0) q[q.size()-1][64] = 1'b1;
        foreach (q[k]) exp_q.push_back(q[k]);
        v.delete();
        delivered = 0;
    endtask

    task automatic put(input logic v0, input int a, input logic v1, input int b, input logic eo);
        port0_valid = v0;
        out_port0 = 25'(a);
        port1_valid = v1;
        out_port1 = 25'(b);
        end_op = eo;
        @(posedge clk);
        #1;
        port0_valid = 0;
        port1_valid = 0;
        end_op = 0;
    endtask

    task automatic wait_done(input int budget, input int words, input logic ovf);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", seen, 1);
        chk("word_cnt", word_cnt, 64'(words));
        chk("exp_remaining", 64'(exp_q.size()), 0);
        chk("overflow", overflow, ovf);
        @(negedge clk);
        chk("done_pulse", done, 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) stalled = 0;
        else begin
            if (stalled) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, held);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", m_data, ~m_data);
                else begin
                    w = exp_q.pop_front();
                    chk("m_data", m_data, w[63:0]);
                    chk("m_last", m_last, w[64]);
                end
                delivered++;
                if (delivered == 1) first_word = m_data;
                last_word = m_data;
                last_flag = m_last;
            end
            stalled = m_valid && !m_ready;
            held = m_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_done", done, 0);
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin add(i); add(-i); end
        build(1, 0);
        put(1, 1, 1, -1, 0);
        put(1, 2, 1, -2, 0);
        chk("latency_before", m_valid, 0);
        put(1, 3, 1, -3, 0);
        chk("latency_valid", m_valid, 1);
        chk("latency_data", m_data, 64'hFFFFFFFF_00000001);
        put(1, 4, 1, -4, 0);
        put(0, 0, 0, 0, 1);
        wait_done(50, 4, 0);
        chk("paired_first", first_word, 64'hFFFFFFFF_00000001);
        chk("paired_last", last_word, 64'hFFFFFFFC_00000004);
        chk("paired_lastflag", last_flag, 1);
        add(5); add(6); add(7);
        build(1, 0);
        put(1, 5, 0, 0, 0);
        put(1, 6, 0, 0, 0);
        put(1, 7, 0, 0, 0);
        put(0, 0, 0, 0, 1);
        wait_done(50, 2, 0);
        chk("odd_first", first_word, 64'h00000006_00000005);
        chk("odd_last", last_word, 64'h00000000_00000007);
        add(1); add(2); add(3);
        build(1, 0);
        put(1, 1, 0, 0, 0);
        put(1, 2, 1, 3, 0);
        put(0, 0, 0, 0, 1);
        wait_done(50, 2, 0);
        chk("mixed_first", first_word, 64'h00000002_00000001);
        chk("mixed_last", last_word, 64'h00000000_00000003);
        build(1, 0);
        put(0, 0, 0, 0, 1);
        wait_done(10, 2, 0);
        chk("idle_end_words", 64'(delivered), 0);
        add(-16777216);
        build(1, 0);
        put(1, -16777216, 0, 0, 0);
        put(0, 0, 0, 0, 1);
        wait_done(50, 1, 0);
        chk("sext_word", last_word, 64'h00000000_FF000000);
        for (int i = 1; i <= 70; i++) begin add(i); add(i + 1000); end
        build(65, 68);
        m_ready = 0;
        for (int i = 1; i <= 70; i++) put(1, i, 1, i + 1000, 0);
        repeat (10) put(0, 0, 0, 0, 0);
        chk("bp_overflow_mid", overflow, 1);
        chk("bp_stalled_head", m_data, 64'h000003E9_00000001);
        m_ready = 1;
        repeat (3) put(0, 0, 0, 0, 0);
        put(0, 0, 0, 0, 1);
        wait_done(300, 66, 1);
        chk("bp_delivered", 64'(delivered), 66);
        chk("bp_last", last_word, 64'h0000042E_00000046);
        m_ready = 0;
        for (int i = 1; i <= 80; i++) put(1, i, 1, -i, 0);
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_overflow", overflow, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_word_cnt", word_cnt, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1;
        m_ready = 1;
        repeat (5) put(0, 0, 0, 0, 0);
        chk("post_rst_valid", m_valid, 0);
        add(9);
        build(1, 0);
        put(1, 9, 0, 0, 0);
        put(0, 0, 0, 0, 1);
        wait_done(50, 1, 0);
        chk("post_rst_word", last_word, 64'h00000000_00000009);
        chk("post_rst_delivered", 64'(delivered), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
